// File: rtl/branch_resolve_pkg.sv
// Shared types for the execute-stage branch path.
//   cmp_op_t    : comparator operation select (consumed by the comparator upstream)
//   br_type_t   : decoded branch/jump class presented to branch_resolve
//   br_state_t  : branch_resolve redirect/flush sequencer states
//   RESET_PC_INC: sequential instruction stride used for fall-through and link
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_type_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_t;

  localparam logic [31:0] RESET_PC_INC = 32'd4;

endpackage

// File: rtl/branch_resolve_bht.sv
// Branch history table of 2-bit saturating counters.
//   clk, rst_n : clock, async active-low reset (all counters -> 2'b01, weakly not-taken)
//   rd_idx     : combinational read index (fetch side)
//   rd_pred    : counter MSB at rd_idx; reflects the array before any same-cycle write
//   wr_en      : train the counter at wr_idx this cycle
//   wr_idx     : training index
//   wr_taken   : actual direction; increments (sat 3) or decrements (sat 0)
module bht_2bit
  import branch_resolve_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_pred,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);

  logic [1:0] ctr [ENTRIES];

  assign rd_pred = ctr[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (wr_en) begin
      if (wr_taken && ctr[wr_idx] != 2'b11)
        ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
      else if (!wr_taken && ctr[wr_idx] != 2'b00)
        ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: computes actual target/link, checks the
// fetch prediction, issues a registered redirect followed by a flush window,
// and trains the BHT that fetch reads.
//   clk, rst_n        : clock, async active-low reset
//   in_valid/in_ready : EX instruction handshake (ready only when idle)
//   br_type, pc, imm, rs1_val, cmp_result : decoded branch and operands
//   pred_taken, pred_target : fetch-time prediction
//   redirect_valid/redirect_pc : one-cycle restart request
//   flush             : kill younger instructions (FLUSH_CYCLES+1 cycles)
//   link_addr         : registered pc+4 of the last accepted instruction
//   misalign          : one-cycle pulse, taken target with bit1 set
//   fetch_pc/fetch_pred : BHT lookup for fetch
// Optional: define BRANCH_STATS_EN to add stat_branches / stat_mispredicts.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  br_type_t    br_type,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        cmp_result,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] link_addr,
  output logic        misalign,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  input  logic [31:0] fetch_pc,
  output logic        fetch_pred
);

  // state    | meaning
  // IDLE     | accepting instructions
  // REDIRECT | redirect pulse cycle, flush high
  // FLUSH    | draining wrong path, flush high, counter runs down to 0

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_t   state, next_state;
  logic [CW-1:0] cnt, cnt_next;

  logic        accept;
  logic        actual_taken;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        mispredict;
  logic        target_misal;
  logic        issue_redirect;

  assign in_ready = (state == IDLE);
  assign flush    = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    actual_taken = 1'b0;
    target       = pc + imm;
    unique case (br_type)
      BR_COND: actual_taken = cmp_result;
      BR_JAL:  actual_taken = 1'b1;
      BR_JALR: begin
        actual_taken = 1'b1;
        target       = (rs1_val + imm) & ~32'h1;
      end
      default: actual_taken = 1'b0;
    endcase
  end

  assign seq_pc         = pc + RESET_PC_INC;
  assign next_pc        = actual_taken ? target : seq_pc;
  assign mispredict     = (actual_taken != pred_taken) ||
                          (actual_taken && (target != pred_target));
  assign target_misal   = actual_taken && target[1];
  // A misaligned taken target traps instead of redirecting.
  assign issue_redirect = accept && mispredict && !target_misal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE:     if (issue_redirect) next_state = REDIRECT;
      REDIRECT: begin
        next_state = FLUSH;
        cnt_next   = CW'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (cnt == '0) next_state = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_addr      <= '0;
      misalign       <= 1'b0;
    end else begin
      redirect_valid <= issue_redirect;
      misalign       <= accept && target_misal;
      if (accept)         link_addr   <= seq_pc;
      if (issue_redirect) redirect_pc <= next_pc;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept && br_type != BR_NONE && stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (issue_redirect && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  // Only the index bits of fetch_pc address the table.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_pc[31:IW+2], fetch_pc[1:0]};

  bht_2bit #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (fetch_pc[IW+1:2]),
    .rd_pred  (fetch_pred),
    .wr_en    (accept && br_type == BR_COND),
    .wr_idx   (pc[IW+1:2]),
    .wr_taken (actual_taken)
  );

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  br_type_t    br_type = BR_NONE;
  logic [31:0] pc = '0, imm = '0, rs1_val = '0, pred_target = '0, fetch_pc = '0;
  logic        cmp_result = 1'b0, pred_taken = 1'b0;
  logic        redirect_valid, flush, misalign, fetch_pred;
  logic [31:0] redirect_pc, link_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve #(.BHT_ENTRIES(64), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .br_type(br_type), .pc(pc), .imm(imm), .rs1_val(rs1_val),
    .cmp_result(cmp_result), .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .link_addr(link_addr), .misalign(misalign),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .fetch_pc(fetch_pc), .fetch_pred(fetch_pred)
  );

  typedef struct {
    br_type_t    bt;
    logic [31:0] pc, imm, rs1;
    logic        cmp, pt;
    logic [31:0] ptgt;
    logic        exp_redir;
    logic [31:0] exp_rpc, exp_link;
    logic        exp_mis;
    logic [31:0] chk_pc;
    logic        exp_pred;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int  fc;
    logic rdy_bad;
    br_type = v.bt; pc = v.pc; imm = v.imm; rs1_val = v.rs1;
    cmp_result = v.cmp; pred_taken = v.pt; pred_target = v.ptgt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d_rv", n), 32'(redirect_valid), 32'(v.exp_redir));
    if (v.exp_redir) chk($sformatf("v%0d_rpc", n), redirect_pc, v.exp_rpc);
    chk($sformatf("v%0d_link", n), link_addr, v.exp_link);
    chk($sformatf("v%0d_mis", n), 32'(misalign), 32'(v.exp_mis));
    chk($sformatf("v%0d_flush", n), 32'(flush), 32'(v.exp_redir));
    if (v.exp_redir) begin
      // wrong-path instruction held on the inputs must be ignored
      br_type = BR_NONE; pc = 32'h0077_7770; pred_taken = 1'b1;
      fc = 0; rdy_bad = 1'b0;
      while (flush === 1'b1 && fc < 20) begin
        if (in_ready !== 1'b0) rdy_bad = 1'b1;
        fc++;
        @(posedge clk); #1;
        if (fc == 1) chk($sformatf("v%0d_rv_pulse", n), 32'(redirect_valid), 32'd0);
      end
      in_valid = 1'b0;
      chk($sformatf("v%0d_flush_len", n), 32'(fc), 32'd3);
      chk($sformatf("v%0d_ready_in_flush", n), 32'(rdy_bad), 32'd0);
      chk($sformatf("v%0d_ready_after", n), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_link_hold", n), link_addr, v.exp_link);
    end else begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_mis_pulse", n), 32'(misalign), 32'd0);
      chk($sformatf("v%0d_no_rv", n), 32'(redirect_valid), 32'd0);
    end
    fetch_pc = v.chk_pc; #1;
    chk($sformatf("v%0d_pred", n), 32'(fetch_pred), 32'(v.exp_pred));
  endtask

  initial begin
    //            bt       pc            imm           rs1           cmp   pt    ptgt          redir rpc           link          mis   chk_pc        pred
    vecs[0]  = '{BR_COND, 32'h200,      32'h10,       32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h204,      1'b0, 32'h200,      1'b0};
    vecs[1]  = '{BR_COND, 32'h40,       32'h10,       32'h0,        1'b1, 1'b1, 32'h50,       1'b0, 32'h0,        32'h44,       1'b0, 32'h40,       1'b1};
    vecs[2]  = '{BR_COND, 32'h40,       32'h10,       32'h0,        1'b1, 1'b1, 32'h50,       1'b0, 32'h0,        32'h44,       1'b0, 32'h40,       1'b1};
    vecs[3]  = '{BR_COND, 32'h40,       32'h10,       32'h0,        1'b1, 1'b1, 32'h50,       1'b0, 32'h0,        32'h44,       1'b0, 32'h40,       1'b1};
    vecs[4]  = '{BR_COND, 32'h40,       32'h10,       32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 32'h44,       32'h44,       1'b0, 32'h40,       1'b1};
    vecs[5]  = '{BR_COND, 32'h40,       32'h10,       32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h44,       1'b0, 32'h40,       1'b0};
    vecs[6]  = '{BR_COND, 32'h100,      32'h20,       32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h120,      32'h104,      1'b0, 32'h100,      1'b0};
    vecs[7]  = '{BR_JALR, 32'h300,      32'h0,        32'h1003,     1'b0, 1'b1, 32'h1002,     1'b0, 32'h0,        32'h304,      1'b1, 32'h300,      1'b0};
    vecs[8]  = '{BR_COND, 32'hFFFFFFFC, 32'h8,        32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFC, 1'b0};
    vecs[9]  = '{BR_JAL,  32'h1000,     32'hFFFFFF00, 32'h0,        1'b0, 1'b1, 32'hF00,      1'b0, 32'h0,        32'h1004,     1'b0, 32'h40,       1'b0};
    vecs[10] = '{BR_JAL,  32'h2000,     32'h100,      32'h0,        1'b0, 1'b1, 32'h2004,     1'b1, 32'h2100,     32'h2004,     1'b0, 32'h40,       1'b0};
    vecs[11] = '{BR_NONE, 32'h500,      32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 32'h504,      32'h504,      1'b0, 32'h40,       1'b0};
    vecs[12] = '{BR_NONE, 32'h600,      32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h604,      1'b0, 32'h40,       1'b0};
    vecs[13] = '{BR_JALR, 32'h700,      32'h10,       32'h3001,     1'b0, 1'b0, 32'h0,        1'b1, 32'h3010,     32'h704,      1'b0, 32'h40,       1'b0};
    vecs[14] = '{BR_COND, 32'h80,       32'h40,       32'h0,        1'b1, 1'b1, 32'h84,       1'b1, 32'hC0,       32'h84,       1'b0, 32'h80,       1'b1};
    vecs[15] = '{BR_COND, 32'h10,       32'h2,        32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h14,       1'b1, 32'h10,       1'b1};

    // reset state
    #3;
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_link", link_addr, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 64; i += 9) begin
      fetch_pc = 32'(i) << 2; #1;
      chk($sformatf("rst_pred_%0d", i), 32'(fetch_pred), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, 32'd14);
    chk("stat_mispredicts", stat_mispredicts, 32'd7);
`endif

    // reset asserted in the middle of the flush window
    br_type = BR_COND; pc = 32'h100; imm = 32'h20; cmp_result = 1'b1; pred_taken = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_flush", 32'(flush), 32'd1);
    fetch_pc = 32'h10; #1;
    chk("pre_rst_pred", 32'(fetch_pred), 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_flush", 32'(flush), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_rv", 32'(redirect_valid), 32'd0);
    fetch_pc = 32'h10; #1;
    chk("mid_rst_pred_4", 32'(fetch_pred), 32'd0);
    fetch_pc = 32'h80; #1;
    chk("mid_rst_pred_32", 32'(fetch_pred), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_flush", 32'(flush), 32'd0);

    // same-cycle write and read of one index returns the old counter
    br_type = BR_COND; pc = 32'h40; imm = 32'h10; cmp_result = 1'b1;
    pred_taken = 1'b1; pred_target = 32'h50; fetch_pc = 32'h40;
    in_valid = 1'b1; #1;
    chk("rw_old", 32'(fetch_pred), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rw_new", 32'(fetch_pred), 32'd1);
    chk("rw_no_rv", 32'(redirect_valid), 32'd0);
    chk("rw_link", link_addr, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
